// File: rtl/rf_wport_arb_if.sv
// Request/writeback bundle for the register-file write-port arbiter.
// master = request sources and observer of the write port; slave = the arbiter.
interface rf_wport_arb_if;
  logic        wb_req;
  logic [4:0]  wb_wn;
  logic [31:0] wb_d;
  logic        lk_req;
  logic        lk_jalr;
  logic [4:0]  lk_rd;
  logic [31:0] lk_pc4;
  logic        c0_req;
  logic [4:0]  c0_rt;
  logic [31:0] c0_d;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_wd;
  logic        stall;
  logic [7:0]  conflict_cnt;

  modport master (
    output wb_req, wb_wn, wb_d, lk_req, lk_jalr, lk_rd, lk_pc4, c0_req, c0_rt, c0_d,
    input  rf_we, rf_wn, rf_wd, stall, conflict_cnt
  );

  modport slave (
    input  wb_req, wb_wn, wb_d, lk_req, lk_jalr, lk_rd, lk_pc4, c0_req, c0_rt, c0_d,
    output rf_we, rf_wn, rf_wd, stall, conflict_cnt
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Merges WB/link/mfc0 writes onto one RF write port; 1-cycle latency, up to 3 on collision.
// stall blocks new requests while any source slot is pending; RFARB_RR_EN selects rotating priority.
module rf_wport_arb (
  input  logic          clk,
  input  logic          clrn,
  rf_wport_arb_if.slave bus
);
  localparam int NSRC = 3;

  logic [NSRC-1:0] slot_v_q, slot_v_d;
  logic [4:0]      slot_n_q [NSRC];
  logic [4:0]      slot_n_d [NSRC];
  logic [31:0]     slot_d_q [NSRC];
  logic [31:0]     slot_d_d [NSRC];

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wn_q, rf_wn_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic        stall_q, stall_d;
  logic [7:0]  conflict_cnt_q, conflict_cnt_d;

  logic [NSRC-1:0] new_v, cand_v, gnt;
  logic [4:0]      new_n  [NSRC];
  logic [31:0]     new_d  [NSRC];
  logic [4:0]      cand_n [NSRC];
  logic [31:0]     cand_d [NSRC];
  logic [4:0]      lk_tgt;
  logic [1:0]      n_new;

  // Requests targeting r0 are dropped before they can occupy a slot or count as a conflict.
  always_comb begin
    lk_tgt   = bus.lk_jalr ? bus.lk_rd : 5'd31;
    new_v[0] = !stall_q && bus.wb_req && (bus.wb_wn != 5'd0);
    new_n[0] = bus.wb_wn;
    new_d[0] = bus.wb_d;
    new_v[1] = !stall_q && bus.lk_req && (lk_tgt != 5'd0);
    new_n[1] = lk_tgt;
    new_d[1] = bus.lk_pc4 + 32'd4;
    new_v[2] = !stall_q && bus.c0_req && (bus.c0_rt != 5'd0);
    new_n[2] = bus.c0_rt;
    new_d[2] = bus.c0_d;
    for (int i = 0; i < NSRC; i++) begin
      cand_v[i] = slot_v_q[i] | new_v[i];
      cand_n[i] = slot_v_q[i] ? slot_n_q[i] : new_n[i];
      cand_d[i] = slot_v_q[i] ? slot_d_q[i] : new_d[i];
    end
  end

`ifdef RFARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] idx;
  logic       multi;

  // Priority only rotates when a real contest happened; a lone drain leaves the order alone.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    multi = (cand_v[0] & cand_v[1]) | (cand_v[0] & cand_v[2]) | (cand_v[1] & cand_v[2]);
    for (int k = 0; k < NSRC; k++) begin
      idx = {1'b0, ptr_q} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if ((gnt == '0) && cand_v[idx[1:0]]) begin
        gnt[idx[1:0]] = 1'b1;
        if (multi) ptr_d = (idx[1:0] == 2'd2) ? 2'd0 : idx[1:0] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt = '0;
    if (cand_v[0])      gnt = 3'b001;
    else if (cand_v[1]) gnt = 3'b010;
    else if (cand_v[2]) gnt = 3'b100;
  end
`endif

  always_comb begin
    rf_we_d = |cand_v;
    rf_wn_d = rf_wn_q;
    rf_wd_d = rf_wd_q;
    for (int i = 0; i < NSRC; i++) begin
      if (gnt[i]) begin
        rf_wn_d = cand_n[i];
        rf_wd_d = cand_d[i];
      end
      slot_n_d[i] = cand_n[i];
      slot_d_d[i] = cand_d[i];
    end
    slot_v_d = cand_v & ~gnt;
    stall_d  = |slot_v_d;
    n_new    = 2'(new_v[0]) + 2'(new_v[1]) + 2'(new_v[2]);
    conflict_cnt_d = conflict_cnt_q;
    if ((n_new >= 2'd2) && (conflict_cnt_q != 8'hFF)) conflict_cnt_d = conflict_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      slot_v_q       <= '0;
      rf_we_q        <= 1'b0;
      rf_wn_q        <= '0;
      rf_wd_q        <= '0;
      stall_q        <= 1'b0;
      conflict_cnt_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        slot_n_q[i] <= '0;
        slot_d_q[i] <= '0;
      end
    end else begin
      slot_v_q       <= slot_v_d;
      rf_we_q        <= rf_we_d;
      rf_wn_q        <= rf_wn_d;
      rf_wd_q        <= rf_wd_d;
      stall_q        <= stall_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int i = 0; i < NSRC; i++) begin
        slot_n_q[i] <= slot_n_d[i];
        slot_d_q[i] <= slot_d_d[i];
      end
    end
  end

  assign bus.rf_we        = rf_we_q;
  assign bus.rf_wn        = rf_wn_q;
  assign bus.rf_wd        = rf_wd_q;
  assign bus.stall        = stall_q;
  assign bus.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: expected writes are queued at issue time and
// popped by a monitor whenever rf_we is seen; status outputs are checked inline.
module tb_rf_wport_arb;
  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] wd;
  } wr_t;

`ifdef RFARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  rf_wport_arb_if bus();
  rf_wport_arb dut (.clk(clk), .clrn(clrn), .bus(bus));

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];
  wr_t mon_got, mon_want;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.wb_req = 1'b0; bus.wb_wn = '0; bus.wb_d = '0;
    bus.lk_req = 1'b0; bus.lk_jalr = 1'b0; bus.lk_rd = '0; bus.lk_pc4 = '0;
    bus.c0_req = 1'b0; bus.c0_rt = '0; bus.c0_d = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] n, input logic [31:0] d);
    exp_q.push_back({n, d});
  endtask

  task automatic drive_3way();
    bus.wb_req = 1'b1; bus.wb_wn = 5'd3; bus.wb_d = 32'd1;
    bus.lk_req = 1'b1; bus.lk_jalr = 1'b0; bus.lk_pc4 = 32'd8;
    bus.c0_req = 1'b1; bus.c0_rt = 5'd3; bus.c0_d = 32'd7;
  endtask

  // WB(r4 or r1) and C0 collide; rotating priority alternates who goes first.
  task automatic collide2(input logic [4:0] wn, input logic [4:0] rt, input logic [31:0] d, input bit c0_first);
    bus.wb_req = 1'b1; bus.wb_wn = wn; bus.wb_d = d;
    bus.c0_req = 1'b1; bus.c0_rt = rt; bus.c0_d = d + 32'd1000;
    if (c0_first) begin
      push(rt, d + 32'd1000); push(wn, d);
    end else begin
      push(wn, d); push(rt, d + 32'd1000);
    end
    tick();
    clr_in();
    tick();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.rf_we === 1'b1) begin
        mon_got = {bus.rf_wn, bus.rf_wd};
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", mon_got.wn, mon_got.wd);
        end else begin
          mon_want = exp_q.pop_front();
          chk("write_wn", 32'(mon_got.wn), 32'(mon_want.wn));
          chk("write_wd", mon_got.wd, mon_want.wd);
        end
      end
    end
  end

  initial begin
    clr_in();
    clrn = 1'b0;
    tick();
    tick();
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_wn", 32'(bus.rf_wn), 32'd0);
    chk("rst_wd", bus.rf_wd, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
    clrn = 1'b1;

    bus.wb_req = 1'b1; bus.wb_wn = 5'd5; bus.wb_d = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    tick();
    clr_in();
    chk("single_we", 32'(bus.rf_we), 32'd1);
    chk("single_stall", 32'(bus.stall), 32'd0);
    tick();

    bus.lk_req = 1'b1; bus.lk_jalr = 1'b0; bus.lk_rd = 5'd7; bus.lk_pc4 = 32'h00400010;
    push(5'd31, 32'h00400014);
    tick();
    clr_in();
    tick();

    bus.lk_req = 1'b1; bus.lk_jalr = 1'b1; bus.lk_rd = 5'd0; bus.lk_pc4 = 32'h00000100;
    tick();
    clr_in();
    chk("jalr_r0_we", 32'(bus.rf_we), 32'd0);
    chk("jalr_r0_stall", 32'(bus.stall), 32'd0);
    tick();

    drive_3way();
    push(5'd3, 32'd1); push(5'd31, 32'd12); push(5'd3, 32'd7);
    tick();
    clr_in();
    chk("c3_stall_1", 32'(bus.stall), 32'd1);
    chk("c3_cnt", 32'(bus.conflict_cnt), 32'd1);
    bus.wb_req = 1'b1; bus.wb_wn = 5'd9; bus.wb_d = 32'h99;
    tick();
    chk("c3_stall_2", 32'(bus.stall), 32'd1);
    tick();
    clr_in();
    chk("c3_stall_3", 32'(bus.stall), 32'd0);
    chk("c3_cnt_after", 32'(bus.conflict_cnt), 32'd1);
    tick();
    tick();

    drive_3way();
    push(5'd3, 32'd1);
    tick();
    clr_in();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    chk("mid_rst_we", 32'(bus.rf_we), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_cnt", 32'(bus.conflict_cnt), 32'd0);
    tick();
    chk("post_rst_we", 32'(bus.rf_we), 32'd0);
    tick();
    tick();

    collide2(5'd4, 5'd5, 32'hA0, 1'b0);
    collide2(5'd4, 5'd5, 32'hA1, RR);
    chk("c2_cnt", 32'(bus.conflict_cnt), 32'd2);

    for (int i = 0; i < 300; i++) begin
      collide2(5'd1, 5'd2, 32'(i), RR && (i % 2 == 1));
      if (i == 251) chk("sat_cnt_254", 32'(bus.conflict_cnt), 32'd254);
    end
    chk("sat_cnt_255", 32'(bus.conflict_cnt), 32'd255);

    tick();
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_wport_arb.md
RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port clrn, input, 1, reset: synchronous, active-low.
REQ-003 SHALL have ports wb_req / wb_wn / wb_d, inputs, 1/5/32: writeback request, target register, data.
REQ-004 SHALL have ports lk_req / lk_jalr / lk_rd / lk_pc4, inputs, 1/1/5/32: link request; jalr select; jalr target; PC+4.
REQ-005 SHALL have ports c0_req / c0_rt / c0_d, inputs, 1/5/32: mfc0 request, target register, CP0 data.
REQ-006 SHALL have ports rf_we / rf_wn / rf_wd, outputs, 1/5/32: the single register-file write port, registered.
REQ-007 SHALL have port stall, output, 1, registered; high means new requests are not accepted this cycle.
REQ-008 SHALL have port conflict_cnt, output, 8, saturating count of cycles with two or more accepted requests.

Function
REQ-009 SHALL compute link target as lk_rd when lk_jalr=1, else 5'd31, and link data as lk_pc4+4 (mod 2^32).
REQ-010 SHALL drop any request whose target is register 0: no write, no slot, no conflict count.
REQ-011 SHALL accept a request only in cycles where stall=0; requests presented while stall=1 SHALL be ignored, and upstream holds them.
REQ-012 SHALL keep one pending slot per source (WB, LK, C0), each holding valid, target and data.
REQ-013 SHALL each cycle form candidates = valid slots plus accepted new requests, grant exactly one candidate, and drive rf_we=1, rf_wn and rf_wd from it on the next edge.
REQ-014 SHALL store non-granted accepted requests into their source slot and clear the granted slot.
REQ-015 SHALL drive rf_we=0 the cycle after no candidate exists; rf_wn and rf_wd then hold their previous value.
REQ-016 SHALL set stall high on the edge when any slot becomes or stays valid, and low when all slots are empty.
REQ-017 SHALL give a request-to-write latency of 1 cycle when granted immediately; at most 3 cycles when three sources collide.
REQ-018 SHALL, for same-target collisions, write in grant order, so the last-granted source's data is final.
REQ-019 SHALL increment conflict_cnt when two or more requests are accepted in one cycle, saturating at 255 with no wrap.
REQ-020 SHALL never issue more than one write per cycle, and never lose or duplicate an accepted request.

Reset
REQ-021 SHALL, on a clk edge with clrn=0, clear all slots and set rf_we=0, rf_wn=0, rf_wd=0, stall=0, conflict_cnt=0 and the grant pointer to WB.
REQ-022 SHALL discard pending slot contents when reset occurs mid-drain; no write is issued on the reset edge or the following cycle unless a new request arrives.

Configuration
REQ-023 SHALL use macro RFARB_RR_EN: when defined, rotating priority; the source granted last becomes lowest priority, and order starts WB>LK>C0 after reset.
REQ-024 SHALL, without RFARB_RR_EN, use fixed priority WB > LK > C0 and omit the grant pointer.

Verification
REQ-025 SHALL test a single request: wb_req=1, wb_wn=5, wb_d=0xDEADBEEF -> next cycle rf_we=1, rf_wn=5, rf_wd=0xDEADBEEF; stall stays 0.
REQ-026 SHALL test link targets: lk_req=1, lk_jalr=0, lk_pc4=0x00400010 -> rf_wn=31, rf_wd=0x00400014; with lk_jalr=1, lk_rd=0 -> no write.
REQ-027 SHALL test a 3-way collision, fixed priority: WB(r3,1), LK(jal, pc4=8), C0(r3,7) same cycle -> writes r3=1, r31=12, r3=7 on 3 consecutive cycles; stall high for 2 cycles; conflict_cnt=1.
REQ-028 SHALL test a 2-way collision with RFARB_RR_EN: WB and C0 collide twice in succession -> first WB then C0, second C0 then WB.
REQ-029 SHALL test reset mid-drain: after a 3-way collision, clrn=0 on the drain cycle -> rf_we=0, stall=0, conflict_cnt=0, and no remaining slot is written.
REQ-030 SHALL test saturation: 300 colliding cycles -> conflict_cnt=255.
